// File: rtl/exec_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer_if
// Description : Handshake and bus bundle between the Oryx instruction
//               sequencer and its environment. This covers instruction and
//               data memory, PC logic, the register file write port and the
//               multi-cycle unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             imem_ack;
    logic [31:0]      ir_in;
    logic             imem_req;
    logic [31:0]      ir_o;
    logic             ir_load;
    logic             mc_start;
    logic             mc_done;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             branch_cond;
    logic             reg_we;
    logic             pc_inc;
    logic             pc_load;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;
    logic             err;

    // Sequencer side
    modport master (
        input  imem_ack, ir_in, mc_done, dmem_ack, branch_cond,
        output imem_req, ir_o, ir_load, mc_start, dmem_req, dmem_we,
               reg_we, pc_inc, pc_load, retired, state_o, err
    );

    // Environment side (memories, PC logic, register file, multi-cycle unit)
    modport slave (
        output imem_ack, ir_in, mc_done, dmem_ack, branch_cond,
        input  imem_req, ir_o, ir_load, mc_start, dmem_req, dmem_we,
               reg_we, pc_inc, pc_load, retired, state_o, err
    );
endinterface
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Multi-cycle instruction sequencer for the Oryx core.
//               FETCH -> DECODE -> EXEC, then optionally MC_WAIT or MEM_WAIT.
//               It issues write-back and PC strobes, counts retired
//               instructions and traps to a sticky error state when a wait
//               exceeds WAIT_LIMIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer #(
    parameter int WAIT_LIMIT = 64,
    parameter int CNT_W      = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    exec_sequencer_if.master  bus
);
    localparam int                WCNT_W    = $clog2(WAIT_LIMIT) + 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MC_WAIT  = 3'd3,
        S_MEM_WAIT = 3'd4,
        S_ERR      = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;

    logic              retire;
    logic              waiting;
    logic              at_limit;
    logic [2:0]        ir_class;
    logic              is_mul;

    // Raw strobes before the reset gate
    logic s_imem_req, s_ir_load, s_mc_start, s_dmem_req, s_dmem_we;
    logic s_reg_we, s_pc_inc, s_pc_load;

    assign ir_class = ir_q[31:29];
    assign is_mul   = (ir_class == 3'd0) && (ir_q[28:27] == 2'b11);
    assign waiting  = (state_q == S_FETCH) || (state_q == S_MC_WAIT) ||
                      (state_q == S_MEM_WAIT);
    assign at_limit = (wait_cnt_q == WAIT_LAST);

    // Next-state, strobe, retire and wait-counter logic
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        err_d      = err_q;
        retire     = 1'b0;
        s_imem_req = 1'b0;
        s_ir_load  = 1'b0;
        s_mc_start = 1'b0;
        s_dmem_req = 1'b0;
        s_dmem_we  = 1'b0;
        s_reg_we   = 1'b0;
        s_pc_inc   = 1'b0;
        s_pc_load  = 1'b0;

        case (state_q)
            S_FETCH: begin
                s_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    s_ir_load = 1'b1;
                    ir_d      = bus.ir_in;
                    state_d   = S_DECODE;
                end else if (at_limit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_class)
                    3'd0: begin
                        if (is_mul) begin
                            s_mc_start = 1'b1;
                            state_d    = S_MC_WAIT;
                        end else begin
                            s_reg_we = 1'b1;
                            s_pc_inc = 1'b1;
                            retire   = 1'b1;
                        end
                    end
                    3'd1: begin
                        s_dmem_req = 1'b1;
                        s_dmem_we  = ir_q[28];
                        state_d    = S_MEM_WAIT;
                    end
                    3'd2: begin
                        s_pc_load = bus.branch_cond;
                        s_pc_inc  = ~bus.branch_cond;
                        retire    = 1'b1;
                    end
                    3'd3: begin
                        s_pc_load = 1'b1;
                        s_reg_we  = ir_q[28];
                        retire    = 1'b1;
                    end
                    3'd5: begin
                        s_mc_start = 1'b1;
                        state_d    = S_MC_WAIT;
                    end
                    default: begin
                        // compare, logic, shift: single-cycle write-back
                        s_reg_we = 1'b1;
                        s_pc_inc = 1'b1;
                        retire   = 1'b1;
                    end
                endcase
            end
            S_MC_WAIT: begin
                if (bus.mc_done) begin
                    s_reg_we = 1'b1;
                    s_pc_inc = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (at_limit) begin
                    state_d = S_ERR;
                end
            end
            S_MEM_WAIT: begin
                s_dmem_req = 1'b1;
                s_dmem_we  = ir_q[28];
                if (bus.dmem_ack) begin
                    s_reg_we = ~ir_q[28];
                    s_pc_inc = 1'b1;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (at_limit) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: state_d = S_ERR;
            // Unused encodings are treated as corruption and trapped
            default: state_d = S_ERR;
        endcase

        if (state_d == S_ERR) begin
            err_d = 1'b1;
        end

        retired_d = retire ? (retired_q + CNT_W'(1)) : retired_q;

        // The counter restarts on every state entry and counts only unanswered wait cycles
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (waiting) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            ir_q       <= '0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
        end
    end

    // Strobes stay silent while reset is held, so an abandoned instruction emits nothing
    assign bus.imem_req = s_imem_req & ~rst;
    assign bus.ir_load  = s_ir_load  & ~rst;
    assign bus.mc_start = s_mc_start & ~rst;
    assign bus.dmem_req = s_dmem_req & ~rst;
    assign bus.dmem_we  = s_dmem_we  & ~rst;
    assign bus.reg_we   = s_reg_we   & ~rst;
    assign bus.pc_inc   = s_pc_inc   & ~rst;
    assign bus.pc_load  = s_pc_load  & ~rst;

    assign bus.ir_o    = ir_q;
    assign bus.retired = retired_q;
    assign bus.state_o = state_q;
    assign bus.err     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Self-checking bench for exec_sequencer. It uses an instruction
//               table, randomized instructions with stray handshakes against
//               a transaction-level model, timeout, reset and counter-wrap
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;
    localparam int WAIT_LIMIT = 64;

    logic clk;
    logic rst;
    logic rst4;

    exec_sequencer_if #(.CNT_W(32)) bus ();
    exec_sequencer_if #(.CNT_W(4))  bus4 ();

    exec_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exec_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] model_ret;
    logic [5:0]  exec_obs;

    typedef struct {
        logic [31:0] ir;
        logic        bc;
        logic [5:0]  exp;   // {mc_start, dmem_req, dmem_we, reg_we, pc_inc, pc_load}
        string       name;
    } vec_t;

    vec_t tab [13];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // {imem_req, ir_load, mc_start, dmem_req, dmem_we, reg_we, pc_inc, pc_load, state_o}
    function automatic logic [10:0] obs();
        return {bus.imem_req, bus.ir_load, bus.mc_start, bus.dmem_req, bus.dmem_we,
                bus.reg_we, bus.pc_inc, bus.pc_load, bus.state_o};
    endfunction

    // Reference: {kind, exec strobes}; kind 0 = done in EXEC, 1 = multi-cycle unit, 2 = memory
    function automatic logic [7:0] exec_model(input logic [31:0] ir, input logic bc);
        logic [2:0] cls;
        cls = ir[31:29];
        if (cls == 3'd5 || (cls == 3'd0 && ir[28:27] == 2'b11)) return 8'b01_100000;
        if (cls == 3'd1) return {2'b10, 1'b0, 1'b1, ir[28], 3'b000};
        if (cls == 3'd2) return {2'b00, 3'b000, 1'b0, ~bc, bc};
        if (cls == 3'd3) return {2'b00, 3'b000, ir[28], 1'b0, 1'b1};
        return 8'b00_000110;
    endfunction

    task automatic drive(input logic ia, input logic [31:0] iin, input logic md,
                         input logic da, input logic bc);
        bus.imem_ack    = ia;
        bus.ir_in       = iin;
        bus.mc_done     = md;
        bus.dmem_ack    = da;
        bus.branch_cond = bc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        logic [10:0] o;
        rst = 1'b1;
        drive(1'b1, 32'h0800_0000, 1'b1, 1'b1, 1'b1);
        repeat (2) begin
            @(negedge clk);
            o = obs();
            check("reset_strobes", 64'(o[10:3]), 64'd0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_ret = 32'd0;
        check("reset_state", 64'(bus.state_o), 64'd0);
        check("reset_ir", 64'(bus.ir_o), 64'd0);
        check("reset_retired", 64'(bus.retired), 64'd0);
        check("reset_err", 64'(bus.err), 64'd0);
    endtask

    // One instruction end to end: fetch after fl stalls, op ack after ol wait cycles
    task automatic run_instr(input logic [31:0] ir, input logic bc, input int fl,
                             input int ol, input bit stray);
        logic [7:0]  e;
        logic [10:0] o;
        logic        done;
        e = exec_model(ir, bc);
        for (int k = 0; k <= fl; k++) begin
            drive(k == fl, (k == fl) ? ir : $urandom, stray & rbit(), stray & rbit(), rbit());
            @(negedge clk);
            check("fetch", 64'(obs()), 64'({1'b1, (k == fl), 6'b0, 3'd0}));
            tick();
        end
        drive(stray & rbit(), $urandom, stray & rbit(), stray & rbit(), rbit());
        @(negedge clk);
        check("decode", 64'(obs()), 64'({8'b0, 3'd1}));
        check("ir_o", 64'(bus.ir_o), 64'(ir));
        tick();
        drive(stray & rbit(), $urandom, stray & rbit(), stray & rbit(), bc);
        @(negedge clk);
        o = obs();
        exec_obs = o[8:3];
        check("exec", 64'(o), 64'({2'b00, e[5:0], 3'd2}));
        tick();
        if (e[7:6] == 2'd1) begin
            for (int k = 0; k <= ol; k++) begin
                done = (k == ol);
                drive(stray & rbit(), $urandom, done, stray & rbit(), rbit());
                @(negedge clk);
                check("mc_wait", 64'(obs()), 64'({5'b0, done, done, 1'b0, 3'd3}));
                tick();
            end
        end else if (e[7:6] == 2'd2) begin
            for (int k = 0; k <= ol; k++) begin
                done = (k == ol);
                drive(stray & rbit(), $urandom, stray & rbit(), done, rbit());
                @(negedge clk);
                check("mem_wait", 64'(obs()),
                      64'({3'b0, 1'b1, ir[28], done & ~ir[28], done, 1'b0, 3'd4}));
                tick();
            end
        end
        model_ret = model_ret + 32'd1;
        check("retired", 64'(bus.retired), 64'(model_ret));
        check("no_err", 64'(bus.err), 64'd0);
    endtask

    initial begin
        logic [10:0] o;
        rst  = 1'b1;
        rst4 = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus4.imem_ack    = 1'b1;
        bus4.ir_in       = 32'h0800_0000;
        bus4.mc_done     = 1'b0;
        bus4.dmem_ack    = 1'b0;
        bus4.branch_cond = 1'b0;
        model_ret = 32'd0;
        exec_obs  = 6'd0;

        tab[0]  = '{32'h0800_0000, 1'b0, 6'b000110, "addi"};
        tab[1]  = '{32'h1000_0000, 1'b0, 6'b000110, "arith_sub2"};
        tab[2]  = '{32'h1800_0000, 1'b0, 6'b100000, "mul"};
        tab[3]  = '{32'h2000_0000, 1'b0, 6'b010000, "load"};
        tab[4]  = '{32'h3000_0000, 1'b1, 6'b011000, "store"};
        tab[5]  = '{32'h4000_0000, 1'b1, 6'b000001, "branch_taken"};
        tab[6]  = '{32'h4000_0000, 1'b0, 6'b000010, "branch_not_taken"};
        tab[7]  = '{32'h6000_0000, 1'b0, 6'b000001, "jump"};
        tab[8]  = '{32'h7000_0000, 1'b0, 6'b000101, "jump_link"};
        tab[9]  = '{32'h8000_0000, 1'b0, 6'b000110, "compare"};
        tab[10] = '{32'hA000_0000, 1'b0, 6'b100000, "flop"};
        tab[11] = '{32'hC000_0000, 1'b0, 6'b000110, "logic"};
        tab[12] = '{32'hE000_0000, 1'b1, 6'b000110, "shift"};

        tick();
        do_reset();

        // Table: each instruction class with immediate fetch and two-cycle op latency
        for (int i = 0; i < 13; i++) begin
            run_instr(tab[i].ir, tab[i].bc, 0, 1, 1'b0);
            check(tab[i].name, 64'(exec_obs), 64'(tab[i].exp));
        end

        // mul with mc_done five cycles after mc_start
        run_instr(32'h1800_0000, 1'b0, 0, 4, 1'b0);

        // Randomized instructions, latencies and stray handshakes
        for (int i = 0; i < 80; i++) begin
            run_instr($urandom, rbit(), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 5)), 1'b1);
        end

        // FLOP whose unit never answers: 64 MC_WAIT cycles, then the trap
        do_reset();
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        for (int k = 0; k < WAIT_LIMIT; k++) begin
            @(negedge clk);
            check("mc_wait_hold", 64'(obs()), 64'({8'b0, 3'd3}));
            tick();
        end
        check("timeout_state", 64'(bus.state_o), 64'd7);
        check("timeout_err", 64'(bus.err), 64'd1);
        drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("err_quiet", 64'(obs()), 64'({8'b0, 3'd7}));
            tick();
        end
        check("err_sticky", 64'(bus.err), 64'd1);
        check("err_ir_frozen", 64'(bus.ir_o), 64'h0000_0000_A000_0000);
        check("err_retired", 64'(bus.retired), 64'd0);

        // Same FLOP, answer in the last permitted cycle
        do_reset();
        run_instr(32'hA000_0000, 1'b0, 0, WAIT_LIMIT - 1, 1'b0);

        // Fetch that is never acknowledged
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < WAIT_LIMIT; k++) begin
            @(negedge clk);
            check("fetch_hold", 64'(obs()), 64'({1'b1, 7'b0, 3'd0}));
            tick();
        end
        check("fetch_timeout_state", 64'(bus.state_o), 64'd7);
        check("fetch_timeout_err", 64'(bus.err), 64'd1);

        // Reset while a load waits for memory
        do_reset();
        run_instr(32'h0800_0000, 1'b0, 0, 0, 1'b0);
        drive(1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        @(negedge clk);
        check("mem_wait_pending", 64'(obs()), 64'({3'b0, 1'b1, 4'b0, 3'd4}));
        tick();
        rst = 1'b1;
        @(negedge clk);
        o = obs();
        check("rst_mid_strobes", 64'(o[10:3]), 64'd0);
        tick();
        check("rst_mid_state", 64'(bus.state_o), 64'd0);
        check("rst_mid_retired", 64'(bus.retired), 64'd0);
        rst = 1'b0;
        model_ret = 32'd0;
        run_instr(32'h0800_0000, 1'b0, 0, 0, 1'b1);

        // 4-bit counter: 17 back-to-back addi wrap to 1
        rst4 = 1'b0;
        repeat (45) tick();
        check("wrap15", 64'(bus4.retired), 64'd15);
        repeat (3) tick();
        check("wrap16", 64'(bus4.retired), 64'd0);
        repeat (3) tick();
        check("wrap17", 64'(bus4.retired), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
